axi4_lite_reg_slave: RTL and testbench
======================================

Name: axi4_lite_reg_slave

Overview:
AXI4-Lite responder exposing a bank of DW-bit registers to a bus master (CPU or the team's AXI master BFM). It accepts AW and W in either order, commits byte-strobed writes and returns B. It serves reads on an independent channel. It drives the RW registers out to user logic and samples read-only status words from it. It is the slave-side counterpart of the team's AXI4-Lite master bench, and it is the register front-end for accelerator cores.

Parameters:
DW, 32, data width; only 32 is supported.
AW, 6, address width in bytes; register index = addr[AW-1:2].
NUM_RW, 8, number of read/write registers, indices 0..NUM_RW-1.
NUM_RO, 4, number of read-only status registers, indices NUM_RW..NUM_RW+NUM_RO-1.

Ports:
s00_axi_aclk  in  1  clock; all logic on posedge.
s00_axi_areset  in  1  synchronous, active-high reset.
s00_axi_awaddr/awprot/awvalid  in  AW/3/1  write address; prot is ignored.
s00_axi_awready  out  1
s00_axi_wdata/wstrb/wvalid  in  DW/DW/8/1  write data.
s00_axi_wready  out  1
s00_axi_bresp/bvalid  out  2/1;  s00_axi_bready  in  1
s00_axi_araddr/arprot/arvalid  in  AW/3/1;  s00_axi_arready  out  1
s00_axi_rdata/rresp/rvalid  out  DW/2/1;  s00_axi_rready  in  1
reg_out  out  NUM_RW*DW  RW register contents; register i sits at [i*DW +: DW].
reg_wr_pulse  out  NUM_RW  one-cycle strobe per register on write commit.
status_in  in  NUM_RO*DW  RO register sources.

Behaviour:
- Reset (synchronous, active-high) sets every output to 0: readies, bvalid, rvalid, bresp, rresp, rdata, reg_out, reg_wr_pulse. Both FSMs return to idle and any latched AW/W is discarded. A transaction in flight when reset asserts is abandoned and gets no response.
- Write FSM has two states, W_IDLE and W_RESP.
  - In W_IDLE: awready = !aw_held && !reset; wready = !w_held && !reset.
  - Each handshake (valid && ready at posedge) latches its payload and sets its held flag.
  - The two handshakes may complete in either order, or on the same edge.
  - On the edge where both are held: commit the write, set bvalid, set bresp, go to W_RESP, clear the held flags.
  - In W_RESP: awready = wready = 0. bvalid stays high, with bresp stable, until bvalid && bready; then go to W_IDLE. awready and wready are high again the cycle after the B handshake.
- Write commit:
  - Index < NUM_RW: merge each byte b where wstrb[b] is set; bresp = OKAY (2'b00); pulse reg_wr_pulse[idx] for one cycle.
  - wstrb == 0: no data change, but still OKAY and still pulse.
  - RO index or out-of-range index: no state change, no pulse, bresp = SLVERR (2'b10).
  - Address bits [1:0] are ignored.
- Read FSM has two states, R_IDLE and R_DATA.
  - In R_IDLE: arready = !reset.
  - On the AR handshake: register rdata and rresp, set rvalid, go to R_DATA. rvalid is visible the cycle after the handshake.
  - Read data by index: RW index → reg_out word; RO index → status_in word sampled at the handshake edge; out of range → rdata 0 with SLVERR.
  - In R_DATA: arready = 0. rdata and rresp are held until rvalid && rready, then go to R_IDLE.
- Read and write channels are independent. If an AR handshake and a write commit to the same register occur on the same edge, the read returns the pre-write value.
- Throughput: one write per 2 cycles (bready tied high); one read per 2 cycles (rready tied high).
- reg_out is registered and reflects a committed write from the cycle after the commit edge.

Optional Feature:
AXI_SLV_STALL_EN: adds parameter STALL_CYCLES (default 3).
- Defined: after both AW and W are held, bvalid waits STALL_CYCLES extra cycles; after the AR handshake, rvalid waits STALL_CYCLES extra cycles. A down-counter provides the delay. The register update and status_in sampling still happen at the original edges. This exercises master wait-handling.
- Undefined: no counter, timing exactly as above.

Decomposition:
- Shared package axi4_lite_pkg:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - wr_state_t {W_IDLE, W_RESP}, rd_state_t {R_IDLE, R_DATA};
  - function byte_merge(old, new, strb).
- One sub-module, axi4_lite_reg_bank: RW storage, strobe merge, wr_pulse generation and the read mux. The top level contains only the two channel FSMs.

Test Plan:
1. Reset for 4 cycles, then release → all outputs 0 during reset; awready, wready and arready = 1 on the first cycle after release; reg_out all 0.
2. W handshake 2 cycles before AW: addr 0x04, data 0xDEADBEEF, wstrb 0xF → wready drops after its handshake; bvalid rises after the AW edge with bresp 00; reg_out[1] = 0xDEADBEEF; reg_wr_pulse[1] high for exactly 1 cycle.
3. Partial strobe: write 0x11223344 with wstrb 0x5 over 0xDEADBEEF → register = 0xDE22BE44; a read of 0x04 returns 0xDE22BE44 with rresp 00.
4. Read RO index 8 (addr 0x20) with status_in word0 = 0xCAFEF00D → rdata 0xCAFEF00D. Write to 0x20 → bresp 10, no reg_out change. Read addr 0x3C → rdata 0, rresp 10.
5. Hold bready low 5 cycles and rready low 3 cycles → bvalid/bresp and rvalid/rdata stay stable; awready, wready and arready stay 0 until the respective handshake.
6. Reset asserted while bvalid is pending → bvalid is 0 after the reset edge, no response is issued, and the next write completes normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - shared response codes, FSM state types and byte-merge helper
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_reg_slave_if.sv
// rtl/axi4_lite_reg_slave_if.sv - AXI4-Lite bus bundle with master/slave modports
interface axi4_lite_reg_slave_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axi4_lite_reg_bank.sv
// rtl/axi4_lite_reg_bank.sv - RW register storage, strobe merge, write pulses and read mux
module axi4_lite_reg_bank
    import axi4_lite_pkg::*;
#(
    parameter int DW     = 32,
    parameter int IW     = 4,
    parameter int NUM_RW = 8,
    parameter int NUM_RO = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IW-1:0]        wr_idx,
    input  logic [DW-1:0]        wr_data,
    input  logic [DW/8-1:0]      wr_strb,
    output logic                 wr_ok,
    input  logic [IW-1:0]        rd_idx,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_ok,
    output logic [NUM_RW*DW-1:0] reg_out,
    output logic [NUM_RW-1:0]    reg_wr_pulse,
    input  logic [NUM_RO*DW-1:0] status_in
);

    logic [NUM_RW-1:0][DW-1:0] regs_q, regs_d;
    logic [NUM_RW-1:0]         pulse_q, pulse_d;

    assign wr_ok = int'(wr_idx) < NUM_RW;
    assign rd_ok = int'(rd_idx) < NUM_RW + NUM_RO;

    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (wr_en && wr_ok) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (int'(wr_idx) == i) begin
                    regs_d[i]  = byte_merge(regs_q[i], wr_data, wr_strb);
                    pulse_d[i] = 1'b1;
                end
            end
        end
    end

    // Reads see the pre-write contents when a commit lands on the same edge.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (int'(rd_idx) == i) rd_data = regs_q[i];
        end
        for (int i = 0; i < NUM_RO; i++) begin
            if (int'(rd_idx) == NUM_RW + i) rd_data = status_in[i*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q  <= '0;
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    assign reg_out      = regs_q;
    assign reg_wr_pulse = pulse_q;

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// rtl/axi4_lite_reg_slave.sv - AXI4-Lite register slave: write and read channel FSMs
// Optional response stall enabled by defining AXI_SLV_STALL_EN.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 6,
    parameter int NUM_RW = 8,
    parameter int NUM_RO = 4
`ifdef AXI_SLV_STALL_EN
    , parameter int STALL_CYCLES = 3
`endif
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_areset,
    axi4_lite_reg_slave_if.slave s00_axi,
    output logic [NUM_RW*DW-1:0] reg_out,
    output logic [NUM_RW-1:0]    reg_wr_pulse,
    input  logic [NUM_RO*DW-1:0] status_in
);

    localparam int IW = AW - 2;
`ifdef AXI_SLV_STALL_EN
    localparam int CW = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
    logic [CW-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
`endif

    wr_state_t       w_state_q, w_state_d;
    logic            aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [IW-1:0]   awidx_q, awidx_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;

    rd_state_t       r_state_q, r_state_d;
    logic            rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;

    logic            aw_hs, w_hs, ar_hs, wr_commit, wr_ok, rd_ok;
    logic [IW-1:0]   wr_idx;
    logic [DW-1:0]   wr_data, rd_data;
    logic [DW/8-1:0] wr_strb;
    logic            unused_bits;

    assign unused_bits = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    assign s00_axi.awready = (w_state_q == W_IDLE) && !aw_held_q && !s00_axi_areset;
    assign s00_axi.wready  = (w_state_q == W_IDLE) && !w_held_q && !s00_axi_areset;
    assign s00_axi.arready = (r_state_q == R_IDLE) && !s00_axi_areset;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = bresp_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = rresp_q;

    assign aw_hs = s00_axi.awvalid && s00_axi.awready;
    assign w_hs  = s00_axi.wvalid && s00_axi.wready;
    assign ar_hs = s00_axi.arvalid && s00_axi.arready;

    // A payload handshaking on the commit edge bypasses its holding register.
    assign wr_idx    = aw_hs ? s00_axi.awaddr[AW-1:2] : awidx_q;
    assign wr_data   = w_hs ? s00_axi.wdata : wdata_q;
    assign wr_strb   = w_hs ? s00_axi.wstrb : wstrb_q;
    assign wr_commit = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    axi4_lite_reg_bank #(
        .DW     (DW),
        .IW     (IW),
        .NUM_RW (NUM_RW),
        .NUM_RO (NUM_RO)
    ) u_bank (
        .clk          (s00_axi_aclk),
        .rst          (s00_axi_areset),
        .wr_en        (wr_commit),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .wr_ok        (wr_ok),
        .rd_idx       (s00_axi.araddr[AW-1:2]),
        .rd_data      (rd_data),
        .rd_ok        (rd_ok),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .status_in    (status_in)
    );

    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
`ifdef AXI_SLV_STALL_EN
        wcnt_d    = wcnt_q;
`endif
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awidx_d   = s00_axi.awaddr[AW-1:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s00_axi.wdata;
                    wstrb_d  = s00_axi.wstrb;
                end
                if (wr_commit) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    w_state_d = W_RESP;
`ifdef AXI_SLV_STALL_EN
                    wcnt_d    = CW'(STALL_CYCLES);
                    bvalid_d  = (STALL_CYCLES == 0);
`else
                    bvalid_d  = 1'b1;
`endif
                end
            end
            W_RESP: begin
                if (bvalid_q && s00_axi.bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
`ifdef AXI_SLV_STALL_EN
                if (!bvalid_q) begin
                    wcnt_d = wcnt_q - CW'(1);
                    if (wcnt_q == CW'(1)) bvalid_d = 1'b1;
                end
`endif
            end
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
`ifdef AXI_SLV_STALL_EN
        rcnt_d    = rcnt_q;
`endif
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rdata_d   = rd_ok ? rd_data : '0;
                    rresp_d   = rd_ok ? RESP_OKAY : RESP_SLVERR;
                    r_state_d = R_DATA;
`ifdef AXI_SLV_STALL_EN
                    rcnt_d    = CW'(STALL_CYCLES);
                    rvalid_d  = (STALL_CYCLES == 0);
`else
                    rvalid_d  = 1'b1;
`endif
                end
            end
            R_DATA: begin
                if (rvalid_q && s00_axi.rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
`ifdef AXI_SLV_STALL_EN
                if (!rvalid_q) begin
                    rcnt_d = rcnt_q - CW'(1);
                    if (rcnt_q == CW'(1)) rvalid_d = 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
`ifdef AXI_SLV_STALL_EN
            wcnt_q    <= '0;
            rcnt_q    <= '0;
`endif
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
`ifdef AXI_SLV_STALL_EN
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// tb/tb_axi4_lite_reg_slave.sv - directed self-checking bench for axi4_lite_reg_slave
module tb_axi4_lite_reg_slave;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] reg_out;
    logic [7:0]   reg_wr_pulse;
    logic [127:0] status_in;
    logic [7:0]   pulse_seen;
    logic [1:0]   resp;
    logic [31:0]  rd;
    int           n_checks = 0;
    int           n_errs   = 0;

    axi4_lite_reg_slave_if #(.AW(6), .DW(32)) bus ();

    axi4_lite_reg_slave #(
        .DW     (32),
        .AW     (6),
        .NUM_RW (8),
        .NUM_RO (4)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_areset (rst),
        .s00_axi        (bus),
        .reg_out        (reg_out),
        .reg_wr_pulse   (reg_wr_pulse),
        .status_in      (status_in)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pulse_seen = pulse_seen | reg_wr_pulse;
    endtask

    function automatic logic [31:0] word(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] st,
                             output logic [1:0] r);
        int   n;
        logic aw_fire, w_fire;
        pulse_seen  = '0;
        bus.awaddr  = a;
        bus.awvalid = 1'b1;
        bus.wdata   = d;
        bus.wstrb   = st;
        bus.wvalid  = 1'b1;
        bus.bready  = 1'b1;
        n = 0;
        while ((bus.awvalid || bus.wvalid || !bus.bvalid) && n < 20) begin
            aw_fire = bus.awvalid && bus.awready;
            w_fire  = bus.wvalid && bus.wready;
            tick();
            if (aw_fire) bus.awvalid = 1'b0;
            if (w_fire)  bus.wvalid  = 1'b0;
            n++;
        end
        check("wr_done_in_time", 32'(n < 20), 32'd1);
        r = bus.bresp;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] r);
        int   n;
        logic ar_fire;
        bus.araddr  = a;
        bus.arvalid = 1'b1;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 20) begin
            ar_fire = bus.arvalid && bus.arready;
            tick();
            if (ar_fire) bus.arvalid = 1'b0;
            n++;
        end
        check("rd_done_in_time", 32'(n < 20), 32'd1);
        d = bus.rdata;
        r = bus.rresp;
        tick();
        bus.rready = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        pulse_seen  = '0;
        status_in   = {32'h0, 32'h0, 32'h12345678, 32'hCAFEF00D};
        bus.awaddr  = '0;
        bus.awprot  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arprot  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;

        // reset state
        repeat (4) tick();
        check("rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'd0);
        check("rst_valids", 32'({bus.bvalid, bus.rvalid, bus.bresp, bus.rresp}), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        check("rst_regs", 32'(reg_out != '0), 32'd0);
        check("rst_pulse", 32'(reg_wr_pulse), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_readies", 32'({bus.awready, bus.wready, bus.arready}), 32'h7);
        check("post_rst_regs", 32'(reg_out != '0), 32'd0);

        // W two cycles ahead of AW
        bus.wdata  = 32'hDEADBEEF;
        bus.wstrb  = 4'hF;
        bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("w_first_wready", 32'(bus.wready), 32'd0);
        check("w_first_awready", 32'(bus.awready), 32'd1);
        tick();
        check("w_first_no_b", 32'(bus.bvalid), 32'd0);
        bus.awaddr  = 6'h04;
        bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("w_first_bvalid", 32'({bus.bvalid, bus.bresp}), 32'h4);
        check("w_first_reg1", word(1), 32'hDEADBEEF);
        check("w_first_pulse", 32'(reg_wr_pulse), 32'h02);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("w_first_pulse_gone", 32'(reg_wr_pulse), 32'h00);
        check("w_first_b_done", 32'({bus.bvalid, bus.awready, bus.wready}), 32'h3);

        // partial strobe
        axi_write(6'h04, 32'h11223344, 4'h5, resp);
        check("partial_bresp", 32'(resp), 32'd0);
        check("partial_reg1", word(1), 32'hDE22BE44);
        check("partial_pulse", 32'(pulse_seen), 32'h02);
        axi_read(6'h04, rd, resp);
        check("partial_rdata", rd, 32'hDE22BE44);
        check("partial_rresp", 32'(resp), 32'd0);

        // read-only, out-of-range and boundary accesses
        axi_read(6'h20, rd, resp);
        check("ro0_rdata", rd, 32'hCAFEF00D);
        check("ro0_rresp", 32'(resp), 32'd0);
        axi_read(6'h24, rd, resp);
        check("ro1_rdata", rd, 32'h12345678);
        axi_write(6'h20, 32'hFFFFFFFF, 4'hF, resp);
        check("ro_wr_bresp", 32'(resp), 32'd2);
        check("ro_wr_pulse", 32'(pulse_seen), 32'd0);
        check("ro_wr_reg0", word(0), 32'd0);
        check("ro_wr_reg1", word(1), 32'hDE22BE44);
        axi_write(6'h30, 32'hFFFFFFFF, 4'hF, resp);
        check("oor_wr_bresp", 32'(resp), 32'd2);
        check("oor_wr_pulse", 32'(pulse_seen), 32'd0);
        axi_read(6'h3C, rd, resp);
        check("oor_rdata", rd, 32'd0);
        check("oor_rresp", 32'(resp), 32'd2);
        axi_write(6'h1F, 32'hA5A5A5A5, 4'hF, resp);
        check("last_rw_bresp", 32'(resp), 32'd0);
        check("last_rw_reg7", word(7), 32'hA5A5A5A5);
        check("last_rw_pulse", 32'(pulse_seen), 32'h80);
        axi_read(6'h1C, rd, resp);
        check("last_rw_rdata", rd, 32'hA5A5A5A5);
        axi_write(6'h04, 32'hFFFFFFFF, 4'h0, resp);
        check("zero_strb_bresp", 32'(resp), 32'd0);
        check("zero_strb_pulse", 32'(pulse_seen), 32'h02);
        check("zero_strb_reg1", word(1), 32'hDE22BE44);

        // back-pressure on B and R
        bus.awaddr  = 6'h08;
        bus.wdata   = 32'h00000055;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("b_stall_state", 32'({bus.bvalid, bus.bresp, bus.awready, bus.wready}), 32'h10);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("b_stall_release", 32'({bus.bvalid, bus.awready, bus.wready}), 32'h3);
        bus.araddr  = 6'h08;
        bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r_stall_state", 32'({bus.rvalid, bus.rresp, bus.arready}), 32'h8);
            check("r_stall_rdata", bus.rdata, 32'h00000055);
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("r_stall_release", 32'({bus.rvalid, bus.arready}), 32'h1);

        // reset with a B response pending
        bus.awaddr  = 6'h0C;
        bus.wdata   = 32'h00000077;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        check("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
        check("pre_rst_reg3", word(3), 32'h00000077);
        rst = 1'b1;
        tick();
        check("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("mid_rst_regs", 32'(reg_out != '0), 32'd0);
        rst = 1'b0;
        bus.bready = 1'b1;
        repeat (3) begin
            tick();
            check("no_stale_b", 32'({bus.bvalid, bus.awready}), 32'h1);
        end
        bus.bready = 1'b0;
        axi_write(6'h0C, 32'h00000099, 4'hF, resp);
        check("post_rst_wr_bresp", 32'(resp), 32'd0);
        check("post_rst_wr_reg3", word(3), 32'h00000099);
        check("post_rst_wr_pulse", 32'(pulse_seen), 32'h08);

        // read and commit on the same edge return the old value
        bus.awaddr  = 6'h08;
        bus.wdata   = 32'hABCD0123;
        bus.wstrb   = 4'hF;
        bus.araddr  = 6'h08;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.arvalid = 1'b0;
        check("same_edge_rvalid", 32'({bus.rvalid, bus.bvalid}), 32'h3);
        check("same_edge_rdata", bus.rdata, 32'd0);
        check("same_edge_reg2", word(2), 32'hABCD0123);
        bus.bready = 1'b1;
        bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0;
        bus.rready = 1'b0;
        check("same_edge_done", 32'({bus.rvalid, bus.bvalid}), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
